// File: rtl/pm_control_sync_pkg.sv
// Shared constants, channel status type and counter sizing for pm_control_sync_filter.
// Edge outputs are built only when PM_CONTROL_SYNC_FILTER_EDGE_DETECT_EN is defined.
package pm_control_sync_pkg;

    localparam int SYNC_DEPTH_MIN    = 2;
    localparam int FILTER_CYCLES_MIN = 1;
    localparam int FILTER_CYCLES_MAX = 65536;

    // Registered per-channel outputs, bundled so the top can fan them out in one place.
    typedef struct packed {
        logic q;
        logic rise;
        logic fall;
        logic busy;
    } ch_status_t;

    function automatic int cnt_width(input int filter_cycles);
        int w;
        w = $clog2(filter_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pm_control_sync_filter_if.sv
// Bundles the asynchronous inputs and filtered/edge/busy outputs of pm_control_sync_filter.
// Plain level signals: no valid/ready handshake, every output is a registered level or pulse valid every CLK cycle.
interface pm_control_sync_filter_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] RISE;
    logic [WIDTH-1:0] FALL;
    logic [WIDTH-1:0] BUSY;

    modport master (
        output D,
        input  Q,
        input  RISE,
        input  FALL,
        input  BUSY
    );

    modport slave (
        input  D,
        output Q,
        output RISE,
        output FALL,
        output BUSY
    );

endinterface

// File: rtl/pm_control_sync_filter_ch.sv
// One channel: synchroniser chain, stability counter and optional edge flops.
// Edge flops exist only when PM_CONTROL_SYNC_FILTER_EDGE_DETECT_EN is defined.
module pm_control_sync_filter_ch
    import pm_control_sync_pkg::*;
#(
    parameter int   SYNC_DEPTH    = 3,
    parameter int   FILTER_CYCLES = 4,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       d_i,
    output ch_status_t status_o
);

    localparam int             CW       = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic [SYNC_DEPTH-1:0] sync_d;
    logic                  s_last;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic                  q_q;
    logic                  q_d;
    logic                  busy_q;
    logic                  rise_w;
    logic                  fall_w;

    assign sync_d = {sync_q[SYNC_DEPTH-2:0], d_i};
    assign s_last = sync_q[SYNC_DEPTH-1];

    // With FILTER_CYCLES == 1 CNT_LAST is 0, so a mismatch is accepted at once and cnt stays 0.
    always_comb begin
        cnt_d = '0;
        q_d   = q_q;
        if (s_last != q_q) begin
            if (cnt_q == CNT_LAST) begin
                q_d = s_last;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Sync stages reload RESET_VAL so releasing reset never produces a false edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= {SYNC_DEPTH{RESET_VAL}};
            cnt_q  <= '0;
            q_q    <= RESET_VAL;
            busy_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            busy_q <= (cnt_d != '0);
        end
    end

`ifdef PM_CONTROL_SYNC_FILTER_EDGE_DETECT_EN
    logic rise_q;
    logic fall_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= q_d & ~q_q;
            fall_q <= ~q_d & q_q;
        end
    end

    assign rise_w = rise_q;
    assign fall_w = fall_q;
`else
    assign rise_w = 1'b0;
    assign fall_w = 1'b0;
`endif

    always_comb begin
        status_o      = '0;
        status_o.q    = q_q;
        status_o.rise = rise_w;
        status_o.fall = fall_w;
        status_o.busy = busy_q;
    end

endmodule

// File: rtl/pm_control_sync_filter.sv
// Multi-channel synchroniser with per-channel glitch filter and edge pulses.
// RISE/FALL registers are built only when PM_CONTROL_SYNC_FILTER_EDGE_DETECT_EN is defined.
module pm_control_sync_filter
    import pm_control_sync_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter int               SYNC_DEPTH    = 3,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
    input  logic                     CLK,
    input  logic                     RST,
    pm_control_sync_filter_if.slave  bus
);

    if (WIDTH < 1 || SYNC_DEPTH < SYNC_DEPTH_MIN ||
        FILTER_CYCLES < FILTER_CYCLES_MIN || FILTER_CYCLES > FILTER_CYCLES_MAX) begin : g_param_check
        $error("pm_control_sync_filter: illegal WIDTH/SYNC_DEPTH/FILTER_CYCLES");
    end

    ch_status_t       status [WIDTH];
    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] busy_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        pm_control_sync_filter_ch #(
            .SYNC_DEPTH    (SYNC_DEPTH),
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_VAL     (RESET_VAL[i])
        ) u_ch (
            .CLK      (CLK),
            .RST      (RST),
            .d_i      (bus.D[i]),
            .status_o (status[i])
        );
    end

    always_comb begin
        q_w    = '0;
        rise_w = '0;
        fall_w = '0;
        busy_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            q_w[i]    = status[i].q;
            rise_w[i] = status[i].rise;
            fall_w[i] = status[i].fall;
            busy_w[i] = status[i].busy;
        end
    end

    assign bus.Q    = q_w;
    assign bus.RISE = rise_w;
    assign bus.FALL = fall_w;
    assign bus.BUSY = busy_w;

endmodule

// File: tb/tb_pm_control_sync_filter.sv
// Bench for pm_control_sync_filter: default-timing DUT (RESET_VAL 4'h5) plus a minimum-configuration DUT.
// Expected Q changes are queued by the driver and popped by negedge monitors.
module tb_pm_control_sync_filter;

`ifdef PM_CONTROL_SYNC_FILTER_EDGE_DETECT_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] q;
        logic [3:0] rise;
        logic [3:0] fall;
    } ev_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_m = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pm_control_sync_filter_if #(.WIDTH(4)) bus ();
    pm_control_sync_filter_if #(.WIDTH(4)) bus_m ();

    pm_control_sync_filter #(
        .WIDTH(4), .SYNC_DEPTH(3), .FILTER_CYCLES(4), .RESET_VAL(4'h5)
    ) dut (
        .CLK(clk), .RST(rst), .bus(bus.slave)
    );

    pm_control_sync_filter #(
        .WIDTH(4), .SYNC_DEPTH(2), .FILTER_CYCLES(1), .RESET_VAL(4'h0)
    ) dut_min (
        .CLK(clk), .RST(rst_m), .bus(bus_m.slave)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    ev_t        exp_q[$];
    logic [3:0] q_model = 4'h5;
    logic [3:0] min_q[$];

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int at, input logic [3:0] qn, input bit edges);
        ev_t e;
        e.cyc  = at;
        e.q    = qn;
        e.rise = (edges && EDGE_EN) ? (qn & ~q_model) : 4'h0;
        e.fall = (edges && EDGE_EN) ? (~qn & q_model) : 4'h0;
        q_model = qn;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // ---------------- monitors ----------------
    bit         mon_en = 1'b0;
    logic [3:0] q_prev;
    ev_t        ev_mon;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.Q !== q_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_q_change: cycle %0d got Q=%h expected no change", cyc, bus.Q);
                end else begin
                    ev_mon = exp_q.pop_front();
                    check_int("event_cycle", cyc, ev_mon.cyc);
                    check4("event_q", bus.Q, ev_mon.q);
                    check4("event_rise", bus.RISE, ev_mon.rise);
                    check4("event_fall", bus.FALL, ev_mon.fall);
                end
            end else begin
                check4("idle_rise_fall", bus.RISE | bus.FALL, 4'h0);
            end
        end
        q_prev = bus.Q;
    end

    logic [3:0] min_exp;
    logic [3:0] min_prev = 4'h0;

    always @(posedge clk) begin
        #1;
        if (min_q.size() >= 3) begin
            min_exp = min_q.pop_front();
            check4("min_q", bus_m.Q, min_exp);
            check4("min_busy", bus_m.BUSY, 4'h0);
            check4("min_rise", bus_m.RISE, EDGE_EN ? (min_exp & ~min_prev) : 4'h0);
            check4("min_fall", bus_m.FALL, EDGE_EN ? (~min_exp & min_prev) : 4'h0);
            min_prev = min_exp;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- drivers ----------------
    logic [3:0] min_vec [13] = '{4'h1, 4'h0, 4'h3, 4'h2, 4'h5, 4'hC, 4'h3,
                                 4'hA, 4'h5, 4'hF, 4'h0, 4'h0, 4'h0};

    task automatic drive_main();
        int t0;
        bus.D = 4'hF;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check4("reset_q", bus.Q, 4'h5);
        check4("reset_rise", bus.RISE, 4'h0);
        check4("reset_fall", bus.FALL, 4'h0);
        check4("reset_busy", bus.BUSY, 4'h0);
        rst    = 1'b0;
        bus.D  = 4'h5;
        mon_en = 1'b1;
        repeat (20) @(negedge clk);
        check4("post_reset_q", bus.Q, 4'h5);
        check4("post_reset_busy", bus.BUSY, 4'h0);

        // clean rise on channel 1
        t0 = cyc;
        bus.D = 4'h7;
        push_ev(t0 + 7, 4'h7, 1'b1);
        wait_cyc(t0 + 3); check4("rise_busy_e3", bus.BUSY, 4'h0);
        wait_cyc(t0 + 4); check4("rise_busy_e4", bus.BUSY, 4'h2);
        wait_cyc(t0 + 6); check4("rise_busy_e6", bus.BUSY, 4'h2);
        wait_cyc(t0 + 7); check4("rise_busy_e7", bus.BUSY, 4'h0);
        wait_cyc(t0 + 8); check4("rise_gone_e8", bus.RISE, 4'h0);
        wait_cyc(t0 + 12);

        // 3-cycle glitch on channel 3 is rejected
        t0 = cyc;
        bus.D = 4'hF;
        wait_cyc(t0 + 3); bus.D = 4'h7;
        wait_cyc(t0 + 6); check4("glitch_busy_e6", bus.BUSY, 4'h8);
        wait_cyc(t0 + 7); check4("glitch_busy_e7", bus.BUSY, 4'h0);
        wait_cyc(t0 + 12); check4("glitch_q", bus.Q, 4'h7);

        // 4-cycle pulse on channel 3 is accepted, then falls
        t0 = cyc;
        bus.D = 4'hF;
        push_ev(t0 + 7, 4'hF, 1'b1);
        push_ev(t0 + 11, 4'h7, 1'b1);
        wait_cyc(t0 + 4); bus.D = 4'h7;
        wait_cyc(t0 + 15);

        // all channels fall, then all rise together
        t0 = cyc;
        bus.D = 4'h0;
        push_ev(t0 + 7, 4'h0, 1'b1);
        wait_cyc(t0 + 12);
        t0 = cyc;
        bus.D = 4'hF;
        push_ev(t0 + 7, 4'hF, 1'b1);
        wait_cyc(t0 + 4); check4("simul_busy_e4", bus.BUSY, 4'hF);
        wait_cyc(t0 + 12);
        t0 = cyc;
        bus.D = 4'h0;
        push_ev(t0 + 7, 4'h0, 1'b1);
        wait_cyc(t0 + 12);

        // reset at edge 5 discards the pending rise on channel 2
        t0 = cyc;
        bus.D = 4'h4;
        push_ev(t0 + 5, 4'h5, 1'b0);
        push_ev(t0 + 12, 4'h4, 1'b1);
        wait_cyc(t0 + 4); check4("midrst_busy_e4", bus.BUSY, 4'h4);
        rst = 1'b1;
        wait_cyc(t0 + 5);
        rst = 1'b0;
        check4("midrst_busy_e5", bus.BUSY, 4'h0);
        wait_cyc(t0 + 11); check4("midrst_q_e11", bus.Q, 4'h5);
        wait_cyc(t0 + 17);
    endtask

    task automatic drive_min();
        bus_m.D = 4'h0;
        rst_m   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check4("min_reset_q", bus_m.Q, 4'h0);
        rst_m = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            bus_m.D = min_vec[i];
            min_q.push_back(min_vec[i]);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus.D   = 4'hF;
        bus_m.D = 4'h0;
        fork
            drive_main();
            drive_min();
        join
        repeat (3) @(negedge clk);
        check_int("events_outstanding", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
